alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-pass command sequencer for the registered 32-bit add/NOT ALU datapath (adder with carry-in tied to 0, NOT of A, 2:1 select mux, output register).
- Accepts ADD, NOT, SUB and NEG commands over a valid/ready handshake.
- Runs one or more datapath passes per command, driving operands and select and capturing the registered result after each pass.
- Returns the final 32-bit result and a carry flag over a second valid/ready handshake.
- Sits between the instruction/control logic and the ALU, and is the only master of the ALU operand and select inputs.

## Interface
Parameters:
- none; data width fixed at 32

Ports:
- clk  input  1  system clock, rising edge; also clocks the ALU output register
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  opcode: 00 ADD, 01 NOT, 10 SUB, 11 NEG
- cmd_a  input  32  operand A
- cmd_b  input  32  operand B; ignored for NOT and NEG
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer takes result
- rsp_data  output  32  final result
- rsp_carry  output  1  carry flag
- busy  output  1  command in flight (state ≠ IDLE)
- alu_a  output  32  to datapath A
- alu_b  output  32  to datapath B
- alu_select  output  1  to datapath mux: 0 = adder, 1 = NOT(A)
- alu_result  input  32  datapath registered output
- alu_cout  input  1  datapath adder carry-out

Decided: one clock; reset is asynchronous and active-low; ports named clk and rst_n.

## Operation
- Operation states: IDLE, EXEC, CAPT, RESP. Per-command registers: latched opcode, A, B, pass counter (0–2), temp (32 bits), carry accumulator.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op/A/B, clear pass counter, temp and carry; go to EXEC.
- EXEC: drive alu_a/alu_b/alu_select for the current pass; go to CAPT.
- CAPT:
  - Sample alu_result into temp.
  - If the pass is an add pass (alu_select=0), OR alu_cout into the carry accumulator. alu_cout is held combinationally, since operands are unchanged in CAPT.
  - If this was the last pass, go to RESP. Otherwise increment the pass counter and go to EXEC.
- RESP:
  - rsp_valid=1; rsp_data=temp; rsp_carry=accumulator.
  - On rsp_ready go to IDLE. Otherwise hold all response outputs stable.
- Pass programs (T = temp):
  - ADD: p0 A+B.
  - NOT: p0 NOT A.
  - SUB: p0 NOT B (alu_a=B, select=1); p1 T+A; p2 T+1.
  - NEG: p0 NOT A; p1 T+1.
- Carry semantics: carry = OR of add-pass carries.
  - SUB: carry=1 iff A≥B unsigned (no borrow).
  - NEG: carry=1 iff A=0.
  - NOT: carry=0.
- Outside EXEC/CAPT: alu_a, alu_b = 0 and alu_select=0. alu_result is never sampled outside CAPT, because the datapath register has no reset.
- Arithmetic is modulo 2^32; no overflow flag.

## Timing
- Reset (rst_n low, any state, including mid-command):
  - Immediately go to IDLE and drop any in-flight command.
  - cmd_ready=0 while rst_n is low; becomes 1 in the first cycle after release.
  - rsp_valid=0, rsp_data=0, rsp_carry=0, busy=0, alu_a=0, alu_b=0, alu_select=0.
- Latency:
  - Cycle 1 is the cycle after the accept edge.
  - rsp_valid rises in cycle 2P+1 for P passes: ADD/NOT cycle 3, NEG cycle 5, SUB cycle 7.
- Throughput: the next command can be accepted in the cycle after the rsp_ready handshake. Minimum command period is 2P+2 cycles.
- cmd_ready=0 in every state except IDLE. cmd_valid outside IDLE is ignored and is not latched.
- Changing cmd_a, cmd_b or cmd_op after acceptance has no effect on the command in flight.
- rsp_ready asserted early (before RESP) has no effect. rsp_ready high on arrival in RESP completes the handshake in that same cycle.

## Test plan
- Reset check: hold rst_n low 3 cycles with cmd_valid=1 → cmd_ready=0, rsp_valid=0, busy=0, all alu_* outputs 0. After release, cmd_ready=1.
- ADD overflow: A=0xFFFFFFFF, B=0x00000001, rsp_ready=1 → rsp_valid in cycle 3, rsp_data=0x00000000, rsp_carry=1.
- NOT: A=0x0F0F0F0F → rsp_data=0xF0F0F0F0, rsp_carry=0.
- SUB, both signs:
  - 5−3 → alu_select sequence 1,0,0; rsp_data=0x00000002, carry=1, rsp_valid in cycle 7.
  - 3−5 → rsp_data=0xFFFFFFFE, carry=0.
- NEG and backpressure: NEG A=0 → rsp_data=0, carry=1. Hold rsp_ready=0 for 4 cycles → outputs stable and cmd_ready=0. Then rsp_ready=1 → IDLE, and back-to-back NEG A=1 gives 0xFFFFFFFF, carry=0.
- Reset mid-SUB: pull rst_n low during the p1 CAPT cycle → no rsp_valid, IDLE after release. A new ADD 2+2 then gives 4, carry=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-pass ADD/NOT/SUB/NEG sequencer for a registered 32-bit add/NOT ALU
//   clk, rst_n                          clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_a/b  command handshake (00 ADD, 01 NOT, 10 SUB, 11 NEG)
//   rsp_valid/rsp_ready/rsp_data/carry  result handshake
//   busy                                command in flight
//   alu_a/alu_b/alu_select              datapath operands and mux select (1 = NOT A)
//   alu_result/alu_cout                 datapath registered result and adder carry-out
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_select,
  input  logic [31:0] alu_result,
  input  logic        alu_cout
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  localparam logic [1:0] OP_ADD = 2'b00, OP_NOT = 2'b01, OP_SUB = 2'b10, OP_NEG = 2'b11;
  state_t state, state_nx;
  logic [1:0] op, pass;
  logic [31:0] a_q, b_q, temp;
  logic carry, last, drive, sel_raw;
  logic [31:0] a_raw, b_raw;
  assign last = pass == (op == OP_SUB ? 2'd2 : op == OP_NEG ? 2'd1 : 2'd0);
  assign drive = state == EXEC || state == CAPT;
  // Pass 0 of SUB/NEG inverts; later passes add the running temp to A or to 1.
  assign sel_raw = op == OP_NOT || (pass == 2'd0 && (op == OP_SUB || op == OP_NEG));
  assign a_raw = (op == OP_SUB && pass == 2'd0) ? b_q : (pass != 2'd0) ? temp : a_q;
  assign b_raw = (op == OP_ADD) ? b_q : (op == OP_SUB && pass == 2'd1) ? a_q :
                 (pass != 2'd0) ? 32'd1 : 32'd0;
  // Operands are held through CAPT so alu_cout still reflects the pass being captured.
  assign alu_a = drive ? a_raw : 32'd0;
  assign alu_b = drive ? b_raw : 32'd0;
  assign alu_select = drive & sel_raw;
  assign cmd_ready = rst_n && state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_data = rsp_valid ? temp : 32'd0;
  assign rsp_carry = rsp_valid & carry;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = cmd_valid ? EXEC : IDLE;
      EXEC: state_nx = CAPT;
      CAPT: state_nx = last ? RESP : EXEC;
      RESP: state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= 2'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      pass <= 2'd0;
      temp <= 32'd0;
      carry <= 1'b0;
    end else if (state == IDLE && cmd_valid) begin
      op <= cmd_op;
      a_q <= cmd_a;
      b_q <= cmd_b;
      pass <= 2'd0;
      temp <= 32'd0;
      carry <= 1'b0;
    end else if (state == CAPT) begin
      temp <= alu_result;
      carry <= carry | (~alu_select & alu_cout);
      pass <= last ? pass : pass + 2'd1;
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a behavioural ALU datapath
module tb_alu_op_sequencer;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_carry, busy, alu_select, alu_cout;
  logic [1:0] cmd_op = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0, rsp_data, alu_a, alu_b, alu_result;
  logic [32:0] sum;
  int errors = 0, checks = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Datapath model: carry-in 0 adder, NOT A, output register without reset.
  assign sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_cout = sum[32];
  always_ff @(posedge clk) alu_result <= alu_select ? ~alu_a : sum[31:0];

  task automatic test_reset();
    rst_n = 0;
    cmd_valid = 1; cmd_op = 2'b00; cmd_a = 32'h1234; cmd_b = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, busy, alu_select} !== 4'b0 || alu_a !== 0 || alu_b !== 0 ||
          rsp_data !== 0 || rsp_carry !== 0) begin
        errors++;
        $display("FAIL reset_hold: ready=%b rvalid=%b busy=%b sel=%b a=%h b=%h data=%h c=%b, required all 0",
                 cmd_ready, rsp_valid, busy, alu_select, alu_a, alu_b, rsp_data, rsp_carry);
      end
    end
    cmd_valid = 0;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  // Caller is at a negedge in IDLE; returns at the negedge of the IDLE cycle after the handshake.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [31:0] a, b,
                         input logic [31:0] exp_d, input logic exp_c, input int exp_lat,
                         input logic [2:0] exp_sel, input int stall);
    int cyc;
    logic [2:0] sel_seq;
    logic [31:0] d0;
    logic c0;
    sel_seq = 3'b000;
    rsp_ready = (stall == 0);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 0; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
    cyc = 1;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: cmd_ready=%b busy=%b, required 0 1", name, cmd_ready, busy);
    end
    while (!rsp_valid && cyc < 20) begin
      if (cyc[0] && cyc <= 5) sel_seq[cyc / 2] = alu_select;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: rsp_valid in cycle %0d, required %0d", name, cyc, exp_lat);
    end
    checks++;
    if (rsp_data !== exp_d || rsp_carry !== exp_c) begin
      errors++;
      $display("FAIL %s_result: data=%h carry=%b, required %h %b", name, rsp_data, rsp_carry, exp_d, exp_c);
    end
    checks++;
    if (sel_seq !== exp_sel) begin
      errors++;
      $display("FAIL %s_select: seq=%b, required %b", name, sel_seq, exp_sel);
    end
    d0 = rsp_data;
    c0 = rsp_carry;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_carry !== c0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_stall: valid=%b data=%h carry=%b ready=%b, required 1 %h %b 0",
                 name, rsp_valid, rsp_data, rsp_carry, cmd_ready, d0, c0);
      end
    end
    rsp_ready = 1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: rsp_valid=%b cmd_ready=%b, required 0 1", name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_add();
    run_cmd("add_ovf", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 3, 3'b000, 0);
  endtask

  task automatic test_not();
    run_cmd("not", 2'b01, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'hF0F0_F0F0, 1'b0, 3, 3'b001, 0);
  endtask

  task automatic test_sub();
    run_cmd("sub_pos", 2'b10, 32'd5, 32'd3, 32'h0000_0002, 1'b1, 7, 3'b001, 0);
    run_cmd("sub_neg", 2'b10, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 7, 3'b001, 0);
  endtask

  task automatic test_back_to_back();
    run_cmd("neg_zero", 2'b11, 32'd0, 32'h5555_5555, 32'h0, 1'b1, 5, 3'b001, 4);
    run_cmd("neg_one", 2'b11, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 5, 3'b001, 0);
  endtask

  task automatic test_reset_mid_sub();
    int seen;
    rsp_ready = 1;
    cmd_valid = 1; cmd_op = 2'b10; cmd_a = 32'd9; cmd_b = 32'd4;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_a !== 0 ||
        alu_b !== 0 || alu_select !== 1'b0) begin
      errors++;
      $display("FAIL midsub_reset: busy=%b ready=%b rvalid=%b a=%h b=%h sel=%b, required all 0",
               busy, cmd_ready, rsp_valid, alu_a, alu_b, alu_select);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midsub_idle: active cycles=%0d cmd_ready=%b, required 0 1", seen, cmd_ready);
    end
    run_cmd("add_after_rst", 2'b00, 32'd2, 32'd2, 32'd4, 1'b0, 3, 3'b000, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_not();
    test_sub();
    test_back_to_back();
    test_reset_mid_sub();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
